// File: rtl/dl_tx_if.sv
// Downlink TX scheduler bus bundle: encoder handshakes, error injection, serializer stream, status.
interface dl_tx_if #(
  parameter int unsigned SER_W  = 10,
  parameter int unsigned ENC0_W = 10,
  parameter int unsigned ENC1_W = 6
);

  logic              enc0_req_i;
  logic [ENC0_W-1:0] enc0_word_i;
  logic              enc0_gnt_o;
  logic              enc0_rd_o;

  logic              enc1_req_i;
  logic [ENC1_W-1:0] enc1_word_i;
  logic              enc1_gnt_o;
  logic              enc1_rd_o;

  logic              err_inj_en_i;
  logic [SER_W-1:0]  err_inj_mask_i;

  logic              ser_valid_o;
  logic              ser_ready_i;
  logic [SER_W-1:0]  ser_data_o;
  logic              ser_sof_o;
  logic              ser_eof_o;
  logic              ser_ch_o;

  logic              busy_o;
  logic [15:0]       frame_cnt_o;

  // Scheduler side
  modport master (
    input  enc0_req_i, enc0_word_i, enc1_req_i, enc1_word_i,
    input  err_inj_en_i, err_inj_mask_i, ser_ready_i,
    output enc0_gnt_o, enc0_rd_o, enc1_gnt_o, enc1_rd_o,
    output ser_valid_o, ser_data_o, ser_sof_o, ser_eof_o, ser_ch_o,
    output busy_o, frame_cnt_o
  );

  // Encoder / serializer environment side
  modport slave (
    output enc0_req_i, enc0_word_i, enc1_req_i, enc1_word_i,
    output err_inj_en_i, err_inj_mask_i, ser_ready_i,
    input  enc0_gnt_o, enc0_rd_o, enc1_gnt_o, enc1_rd_o,
    input  ser_valid_o, ser_data_o, ser_sof_o, ser_eof_o, ser_ch_o,
    input  busy_o, frame_cnt_o
  );

endinterface

// File: rtl/dl_tx_scheduler.sv
// Downlink TX scheduler: round-robin arbitration between two encoders, then
// streams a preamble followed by the granted encoder's payload to the serializer.
module dl_tx_scheduler #(
  parameter int unsigned      SER_W      = 10,
  parameter int unsigned      ENC0_W     = 10,
  parameter int unsigned      ENC0_DEPTH = 8,
  parameter int unsigned      ENC1_W     = 6,
  parameter int unsigned      ENC1_DEPTH = 4,
  parameter int unsigned      PRE_CNT    = 4,
  parameter logic [SER_W-1:0] PRE_WORD   = 10'h2AA
) (
  input logic    clk,
  input logic    rst_n,
  dl_tx_if.master bus
);

  localparam int unsigned MAX_DEPTH = (ENC0_DEPTH > ENC1_DEPTH) ? ENC0_DEPTH : ENC1_DEPTH;
  localparam int unsigned WCW       = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int unsigned PCW       = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;

  localparam logic [WCW-1:0] LAST0    = WCW'(ENC0_DEPTH - 1);
  localparam logic [WCW-1:0] LAST1    = WCW'(ENC1_DEPTH - 1);
  localparam logic [PCW-1:0] PRE_LAST = PCW'(PRE_CNT - 1);

  logic [1:0]       state_q, state_d;
  logic             ch_q, ch_d;
  logic             last_ch_q, last_ch_d;
  logic [PCW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic             inj_en_q, inj_en_d;
  logic [SER_W-1:0] inj_mask_q, inj_mask_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             active;
  logic             xfer;
  logic [WCW-1:0]   last_idx;
  logic [SER_W-1:0] ser_data;

  assign active   = (state_q != ST_IDLE);
  assign xfer     = active && bus.ser_ready_i;
  assign last_idx = ch_q ? LAST1 : LAST0;

  // Next-state logic: arbitration in IDLE, word counting in PREAMBLE/PAYLOAD
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    last_ch_d   = last_ch_q;
    pre_cnt_d   = pre_cnt_q;
    word_cnt_d  = word_cnt_q;
    inj_en_d    = inj_en_q;
    inj_mask_d  = inj_mask_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enc0_req_i || bus.enc1_req_i) begin
          state_d    = ST_PRE;
          // Tie goes to the channel that did not send the previous frame
          ch_d       = (bus.enc0_req_i && bus.enc1_req_i) ? ~last_ch_q : bus.enc1_req_i;
          pre_cnt_d  = '0;
          inj_en_d   = bus.err_inj_en_i;
          inj_mask_d = bus.err_inj_mask_i;
        end
      end
      ST_PRE: begin
        if (xfer) begin
          if (pre_cnt_q == PRE_LAST) begin
            state_d    = ST_PAY;
            word_cnt_d = '0;
          end else begin
            pre_cnt_d = pre_cnt_q + PCW'(1);
          end
        end
      end
      ST_PAY: begin
        if (xfer) begin
          if (word_cnt_q == last_idx) begin
            state_d     = ST_IDLE;
            last_ch_d   = ch_q;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and frame context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= 1'b0;
      last_ch_q   <= 1'b1;
      pre_cnt_q   <= '0;
      word_cnt_q  <= '0;
      inj_en_q    <= 1'b0;
      inj_mask_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      last_ch_q   <= last_ch_d;
      pre_cnt_q   <= pre_cnt_d;
      word_cnt_q  <= word_cnt_d;
      inj_en_q    <= inj_en_d;
      inj_mask_q  <= inj_mask_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Serializer word mux: preamble constant or pass-through encoder word with optional error on word 0
  always_comb begin
    ser_data = '0;
    if (state_q == ST_PRE) begin
      ser_data = PRE_WORD;
    end else if (state_q == ST_PAY) begin
      ser_data = ch_q ? SER_W'(bus.enc1_word_i) : SER_W'(bus.enc0_word_i);
      if (inj_en_q && (word_cnt_q == '0)) begin
        ser_data = ser_data ^ inj_mask_q;
      end
    end
  end

  assign bus.ser_valid_o = active;
  assign bus.busy_o      = active;
  assign bus.ser_data_o  = ser_data;
  assign bus.ser_sof_o   = (state_q == ST_PRE) && (pre_cnt_q == '0);
  assign bus.ser_eof_o   = (state_q == ST_PAY) && (word_cnt_q == last_idx);
  assign bus.ser_ch_o    = ch_q;
  assign bus.enc0_gnt_o  = active && !ch_q;
  assign bus.enc1_gnt_o  = active && ch_q;
  assign bus.enc0_rd_o   = (state_q == ST_PAY) && !ch_q && bus.ser_ready_i;
  assign bus.enc1_rd_o   = (state_q == ST_PAY) && ch_q && bus.ser_ready_i;
  assign bus.frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_dl_tx_scheduler.sv
// Self-checking bench for dl_tx_scheduler: directed scenarios plus randomized frames
// checked against a transfer-level reference model.
module tb_dl_tx_scheduler;

  localparam int unsigned      SER_W      = 10;
  localparam int unsigned      ENC0_W     = 10;
  localparam int unsigned      ENC0_DEPTH = 8;
  localparam int unsigned      ENC1_W     = 6;
  localparam int unsigned      ENC1_DEPTH = 4;
  localparam int unsigned      PRE_CNT    = 4;
  localparam logic [SER_W-1:0] PRE_WORD   = 10'h2AA;
  localparam int               LEN0       = int'(PRE_CNT + ENC0_DEPTH);

  typedef struct {
    logic [SER_W-1:0] data;
    logic             sof;
    logic             eof;
    logic             ch;
    logic             pay;
  } xfer_t;

  logic clk;
  logic rst_n;

  dl_tx_if #(.SER_W(SER_W), .ENC0_W(ENC0_W), .ENC1_W(ENC1_W)) bus ();

  dl_tx_scheduler #(
    .SER_W(SER_W), .ENC0_W(ENC0_W), .ENC0_DEPTH(ENC0_DEPTH),
    .ENC1_W(ENC1_W), .ENC1_DEPTH(ENC1_DEPTH), .PRE_CNT(PRE_CNT), .PRE_WORD(PRE_WORD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  xfer_t             exp_q[$];
  logic [ENC0_W-1:0] src0 [ENC0_DEPTH];
  logic [ENC1_W-1:0] src1 [ENC1_DEPTH];
  int                idx0 = 0;
  int                idx1 = 0;
  int                rd0_cnt = 0;
  int                rd1_cnt = 0;
  logic              stall_q = 1'b0;
  logic [SER_W+2:0]  st_word = '0;
  logic              model_last = 1'b1;
  int                model_frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic arb(input logic r0, input logic r1);
    return (r0 && r1) ? !model_last : r1;
  endfunction

  function automatic logic ready_for(input int mode, input int n);
    logic [3:0] pat;
    pat = 4'b1001;
    case (mode)
      1:       return pat[(n - 1) % 4];
      2:       return ($urandom_range(0, 3) != 0);
      default: return 1'b1;
    endcase
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < int'(ENC0_DEPTH); i++) src0[i] = ENC0_W'($urandom);
    for (int i = 0; i < int'(ENC1_DEPTH); i++) src1[i] = ENC1_W'($urandom);
  endtask

  // Expected serializer stream of one frame, built from the current source contents
  task automatic expect_frame(input logic ch, input logic en, input logic [SER_W-1:0] mask);
    int d;
    logic [SER_W-1:0] w;
    d = ch ? int'(ENC1_DEPTH) : int'(ENC0_DEPTH);
    for (int i = 0; i < int'(PRE_CNT); i++)
      exp_q.push_back('{data: PRE_WORD, sof: (i == 0), eof: 1'b0, ch: ch, pay: 1'b0});
    for (int i = 0; i < d; i++) begin
      w = ch ? SER_W'(src1[i]) : SER_W'(src0[i]);
      if (en && i == 0) w = w ^ mask;
      exp_q.push_back('{data: w, sof: 1'b0, eof: (i == d - 1), ch: ch, pay: 1'b1});
    end
  endtask

  // One clock: drive encoder words and ready, then check handshake and transfers
  task automatic cycle(input logic ready);
    xfer_t e;
    logic has, fire;
    logic [SER_W+2:0] cur;
    @(posedge clk);
    #1;
    bus.ser_ready_i = ready;
    bus.enc0_word_i = src0[idx0 % int'(ENC0_DEPTH)];
    bus.enc1_word_i = src1[idx1 % int'(ENC1_DEPTH)];
    #1;
    has = (exp_q.size() != 0);
    if (has) e = exp_q[0];
    else e = '{data: '0, sof: 1'b0, eof: 1'b0, ch: 1'b0, pay: 1'b0};
    cur = {bus.ser_data_o, bus.ser_sof_o, bus.ser_eof_o, bus.ser_ch_o};
    if (stall_q) chk("hold_stable", 32'(cur), 32'(st_word));
    chk("valid_vs_busy", 32'(bus.ser_valid_o), 32'(bus.busy_o));
    chk("gnt0", 32'(bus.enc0_gnt_o), 32'(bus.busy_o && has && !e.ch));
    chk("gnt1", 32'(bus.enc1_gnt_o), 32'(bus.busy_o && has && e.ch));
    fire = bus.ser_valid_o && bus.ser_ready_i;
    chk("rd0", 32'(bus.enc0_rd_o), 32'(fire && has && e.pay && !e.ch));
    chk("rd1", 32'(bus.enc1_rd_o), 32'(fire && has && e.pay && e.ch));
    if (fire) begin
      chk("xfer_expected", 32'(has), 32'd1);
      if (has) begin
        chk("xfer_word", 32'(cur), 32'({e.data, e.sof, e.eof, e.ch}));
        void'(exp_q.pop_front());
      end
    end
    stall_q = bus.ser_valid_o && !bus.ser_ready_i;
    st_word = cur;
    if (bus.enc0_rd_o) begin idx0++; rd0_cnt++; end
    if (bus.enc1_rd_o) begin idx1++; rd1_cnt++; end
  endtask

  // Request, drop request once granted (and scramble injection inputs), run to idle
  task automatic run_frame(input logic r0, input logic r1, input int mode,
                           output int first_busy, output int n_idle);
    int n;
    logic started;
    n = 0; started = 1'b0; first_busy = 0; n_idle = 0;
    rd0_cnt = 0; rd1_cnt = 0;
    bus.enc0_req_i = r0;
    bus.enc1_req_i = r1;
    while (n < 400 && n_idle == 0) begin
      n++;
      cycle(ready_for(mode, n));
      if (!started && bus.busy_o) begin
        started = 1'b1;
        first_busy = n;
        bus.enc0_req_i = 1'b0;
        bus.enc1_req_i = 1'b0;
        bus.err_inj_en_i = ~bus.err_inj_en_i;
        bus.err_inj_mask_i = SER_W'($urandom);
      end else if (started && !bus.busy_o) begin
        n_idle = n;
      end
    end
    chk("frame_finished", 32'(n_idle != 0), 32'd1);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({bus.enc0_gnt_o, bus.enc0_rd_o, bus.enc1_gnt_o, bus.enc1_rd_o,
                            bus.ser_valid_o, bus.ser_sof_o, bus.ser_eof_o, bus.ser_ch_o,
                            bus.busy_o}), 32'd0);
    chk({tag, "_data"}, 32'(bus.ser_data_o), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(bus.frame_cnt_o), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   fb, ni, low_run, r;
    logic seen, ch, en;
    logic [SER_W-1:0] mask;

    // Reset with both requests already pending
    rst_n = 1'b1;
    bus.enc0_req_i = 1'b1;
    bus.enc1_req_i = 1'b1;
    bus.enc0_word_i = '0;
    bus.enc1_word_i = '0;
    bus.err_inj_en_i = 1'b0;
    bus.err_inj_mask_i = '0;
    bus.ser_ready_i = 1'b1;
    for (int i = 0; i < int'(ENC0_DEPTH); i++) src0[i] = '0;
    for (int i = 0; i < int'(ENC1_DEPTH); i++) src1[i] = '0;
    #1 rst_n = 1'b0;
    repeat (3) cycle(1'b1);
    chk_zero("reset");

    // Tie from reset: enc0, bubble, enc1, bubble, enc0
    fill_rand();
    src1[0] = 6'h3F;
    ch = arb(1'b1, 1'b1); model_last = ch; expect_frame(ch, 1'b0, '0);
    ch = arb(1'b1, 1'b1); model_last = ch; expect_frame(ch, 1'b0, '0);
    ch = arb(1'b1, 1'b1); model_last = ch; expect_frame(ch, 1'b0, '0);
    rst_n = 1'b1;
    seen = 1'b0; low_run = 0;
    for (int n = 0; n < 300; n++) begin
      cycle(1'b1);
      if (bus.busy_o) begin
        if (seen && low_run != 0) chk("bubble_len", 32'(low_run), 32'd1);
        seen = 1'b1; low_run = 0;
      end else if (seen) begin
        low_run++;
      end
      if (bus.enc0_gnt_o && int'(exp_q.size()) == LEN0) begin
        bus.enc0_req_i = 1'b0;
        bus.enc1_req_i = 1'b0;
      end
      if (seen && !bus.busy_o && exp_q.size() == 0) break;
    end
    chk("tie_drained", 32'(exp_q.size()), 32'd0);
    chk("tie_frame_cnt", 32'(bus.frame_cnt_o), 32'd3);

    // Fresh reset, then the basic single enc0 frame with words 1..8
    rst_n = 1'b0;
    repeat (2) cycle(1'b1);
    rst_n = 1'b1;
    model_last = 1'b1; model_frames = 0;
    for (int i = 0; i < int'(ENC0_DEPTH); i++) src0[i] = ENC0_W'(i + 1);
    bus.err_inj_en_i = 1'b0;
    ch = arb(1'b1, 1'b0);
    expect_frame(ch, 1'b0, '0);
    run_frame(1'b1, 1'b0, 0, fb, ni);
    model_last = ch; model_frames++;
    chk("single_grant_latency", 32'(fb), 32'd1);
    chk("single_req_to_idle", 32'(ni), 32'd13);
    chk("single_rd0_pulses", 32'(rd0_cnt), 32'(ENC0_DEPTH));
    chk("single_frame_cnt", 32'(bus.frame_cnt_o), 32'(model_frames));

    // Backpressure with ready pattern 1,0,0,1
    fill_rand();
    bus.err_inj_en_i = 1'b0;
    ch = arb(1'b1, 1'b0);
    expect_frame(ch, 1'b0, '0);
    run_frame(1'b1, 1'b0, 1, fb, ni);
    model_last = ch; model_frames++;
    chk("bp_rd0_pulses", 32'(rd0_cnt), 32'(ENC0_DEPTH));
    chk("bp_rd1_pulses", 32'(rd1_cnt), 32'd0);
    chk("bp_frame_cnt", 32'(bus.frame_cnt_o), 32'(model_frames));

    // Error injection latched at grant; mask scrambled after grant must not matter
    fill_rand();
    src0[0] = 10'h001;
    bus.err_inj_en_i = 1'b1;
    bus.err_inj_mask_i = 10'h201;
    ch = arb(1'b1, 1'b0);
    expect_frame(ch, 1'b1, 10'h201);
    run_frame(1'b1, 1'b0, 0, fb, ni);
    model_last = ch; model_frames++;
    chk("inj_frame_cnt", 32'(bus.frame_cnt_o), 32'(model_frames));

    // Randomized frames: random requests, words, injection and ready
    for (int f = 0; f < 8; f++) begin
      r = int'($urandom_range(1, 3));
      fill_rand();
      en = 1'($urandom_range(0, 1));
      mask = SER_W'($urandom);
      bus.err_inj_en_i = en;
      bus.err_inj_mask_i = mask;
      ch = arb(r[0], r[1]);
      expect_frame(ch, en, mask);
      run_frame(r[0], r[1], 2, fb, ni);
      model_last = ch; model_frames++;
      chk("rand_rd_own", 32'(ch ? rd1_cnt : rd0_cnt), 32'(ch ? ENC1_DEPTH : ENC0_DEPTH));
      chk("rand_rd_other", 32'(ch ? rd0_cnt : rd1_cnt), 32'd0);
      chk("rand_frame_cnt", 32'(bus.frame_cnt_o), 32'(model_frames));
    end

    // Async reset during payload word 3
    fill_rand();
    bus.err_inj_en_i = 1'b0;
    ch = arb(1'b1, 1'b0);
    expect_frame(ch, 1'b0, '0);
    bus.enc0_req_i = 1'b1;
    for (int n = 0; n < 100 && int'(exp_q.size()) > LEN0 - int'(PRE_CNT) - 3; n++) begin
      cycle(1'b1);
      if (bus.busy_o) bus.enc0_req_i = 1'b0;
    end
    chk("rst_reached_word3", 32'(exp_q.size()), 32'(LEN0 - int'(PRE_CNT) - 3));
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("midframe_reset");
    exp_q.delete();
    idx0 = 0; idx1 = 0; stall_q = 1'b0; rd0_cnt = 0; rd1_cnt = 0;
    repeat (3) cycle(1'b1);
    chk("reset_no_rd", 32'(rd0_cnt + rd1_cnt), 32'd0);
    chk("reset_frame_cnt", 32'(bus.frame_cnt_o), 32'd0);
    rst_n = 1'b1;
    model_last = 1'b1; model_frames = 0;
    fill_rand();
    ch = arb(1'b1, 1'b1);
    expect_frame(ch, 1'b0, '0);
    run_frame(1'b1, 1'b1, 0, fb, ni);
    model_last = ch; model_frames++;
    chk("post_reset_tie_rd0", 32'(rd0_cnt), 32'(ENC0_DEPTH));
    chk("post_reset_frame_cnt", 32'(bus.frame_cnt_o), 32'(model_frames));

    // Frame counter wrap via backdoor preload
    force dut.frame_cnt_q = 16'hFFFF;
    cycle(1'b1);
    release dut.frame_cnt_q;
    #1 chk("preload_frame_cnt", 32'(bus.frame_cnt_o), 32'h0000FFFF);
    model_frames = 16'hFFFF;
    fill_rand();
    bus.err_inj_en_i = 1'b0;
    ch = arb(1'b0, 1'b1);
    expect_frame(ch, 1'b0, '0);
    run_frame(1'b0, 1'b1, 2, fb, ni);
    model_last = ch; model_frames = (model_frames + 1) & 16'hFFFF;
    chk("wrap_frame_cnt", 32'(bus.frame_cnt_o), 32'(model_frames));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dl_tx_scheduler.md
DL_TX_SCHEDULER -- requirements
Module: dl_tx_scheduler

Interface
REQ-001 SHALL have parameter SER_W, default 10, meaning the serializer word width (SERIAL_DATA_WIDTH).
REQ-002 SHALL have parameter ENC0_W, default 10, meaning the encoder-0 word width (ENC0_PAR_DATA_WIDTH).
REQ-003 SHALL have parameter ENC0_DEPTH, default 8, meaning encoder-0 words per frame.
REQ-004 SHALL have parameter ENC1_W, default 6, meaning the encoder-1 word width (ENC1_PAR_DATA_WIDTH).
REQ-005 SHALL have parameter ENC1_DEPTH, default 4, meaning encoder-1 words per frame.
REQ-006 SHALL have parameter PRE_CNT, default 4, meaning preamble words per frame (DL_PREAMBLE_COUNT, power of 2).
REQ-007 SHALL have parameter PRE_WORD, default 10'h2AA, meaning the preamble word value.
REQ-008 SHALL have ports: clk input 1 system clock; rst_n input 1 asynchronous active-low reset.
REQ-009 SHALL have ports: enc0_req_i input 1 frame ready; enc0_word_i input ENC0_W current word; enc0_gnt_o output 1 grant; enc0_rd_o output 1 word pop.
REQ-010 SHALL have ports: enc1_req_i input 1; enc1_word_i input ENC1_W; enc1_gnt_o output 1; enc1_rd_o output 1 (same meanings as encoder 0).
REQ-011 SHALL have ports: err_inj_en_i input 1 error-injection enable; err_inj_mask_i input SER_W XOR mask.
REQ-012 SHALL have ports: ser_valid_o output 1; ser_ready_i input 1; ser_data_o output SER_W; ser_sof_o output 1; ser_eof_o output 1; ser_ch_o output 1 (active channel).
REQ-013 SHALL have ports: busy_o output 1 (state not IDLE); frame_cnt_o output 16 (completed frames).

Function
REQ-014 SHALL implement the FSM states IDLE, PREAMBLE and PAYLOAD.
REQ-015 In IDLE, enc*_req_i SHALL be sampled every cycle; one active request SHALL be granted; with two active requests, the channel other than last_ch SHALL be granted (round-robin).
REQ-016 On a grant in cycle N: enc*_gnt_o, busy_o and ser_valid_o SHALL be high from N+1; the state SHALL be PREAMBLE at N+1; ser_ch_o SHALL be latched.
REQ-017 err_inj_en_i and err_inj_mask_i SHALL be latched at the grant and SHALL be ignored for the rest of the frame.
REQ-018 A transfer SHALL occur when ser_valid_o && ser_ready_i; ser_data_o, ser_sof_o, ser_eof_o and ser_ch_o SHALL be held stable while ser_valid_o=1 and ser_ready_i=0.
REQ-019 In PREAMBLE, the block SHALL emit PRE_CNT words of PRE_WORD; ser_sof_o SHALL be high on the first preamble word only; after the last preamble transfer, the state SHALL become PAYLOAD.
REQ-020 In PAYLOAD, the block SHALL emit DEPTH words of the granted channel; ser_data_o SHALL equal the combinational enc word, zero-extended to SER_W.
REQ-021 Payload word index 0 SHALL be XORed with the latched mask when the latched enable is 1.
REQ-022 enc*_rd_o SHALL be high exactly in each cycle that a payload word of that channel transfers, for a total of DEPTH pulses per frame; it SHALL never be high for a non-granted channel.
REQ-023 ser_eof_o SHALL be high on the last payload word only.
REQ-024 After the last payload transfer, the next cycle SHALL be IDLE: gnt, valid and busy low; last_ch updated; frame_cnt_o incremented by 1 and wrapping from 16'hFFFF to 0.
REQ-025 The earliest re-grant SHALL be the cycle after the return to IDLE, giving one idle bubble between frames.
REQ-026 A request dropped mid-frame SHALL NOT abort the frame; requests SHALL be ignored outside IDLE.
REQ-027 The preamble counter SHALL be log2(PRE_CNT) bits and the word counter SHALL be clog2(max DEPTH) bits; both SHALL be cleared on entry to their state.

Reset
REQ-028 When rst_n=0, the block SHALL immediately (asynchronously) enter IDLE.
REQ-029 When rst_n=0, all outputs SHALL be driven to 0.
REQ-030 When rst_n=0, last_ch SHALL reset to 1 (encoder 0 wins the first tie), counters SHALL reset to 0, and the latched mask/enable SHALL reset to 0.
REQ-031 Reset mid-frame SHALL discard the frame with no further rd pulses, and frame_cnt_o SHALL read 0.

Verification
REQ-032 The bench SHALL cover single frame: enc0_req_i=1, ser_ready_i=1, words 0x001..0x008 -> 4x 0x2AA (sof on 1st), 0x001..0x008 (eof on 0x008), 8 rd pulses, frame_cnt_o=1, 13 cycles from req to IDLE.
REQ-033 The bench SHALL cover tie and round-robin: both requests held from reset -> enc0 frame, bubble, enc1 frame (ser_ch_o=1, 4 payload words zero-extended, e.g. 6'h3F -> 10'h03F), then enc0 again.
REQ-034 The bench SHALL cover backpressure: ser_ready_i toggling 1,0,0,1 on each word -> no duplicate or lost words, outputs stable while stalled, rd pulses only on accepted cycles.
REQ-035 The bench SHALL cover error injection: err_inj_en_i=1, mask 10'h201 at grant, first word 0x001 -> emitted 0x200; change the mask mid-frame -> no effect; remaining words unchanged.
REQ-036 The bench SHALL cover async reset: assert rst_n=0 during payload word 3 -> all outputs 0 in the same cycle; after release, enc0 and enc1 tie -> enc0 granted.
REQ-037 The bench SHALL cover counter wrap: force 65536 frames (or preload via backdoor 16'hFFFF) -> frame_cnt_o = 0.
